// File: rtl/user_bus_pkg.sv
// Shared definitions for the user-project RAM bus: FSM states, master indices and
// the round-robin pointer increment.
package user_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int unsigned M_CPU       = 0;
  localparam int unsigned M_DMA_IN    = 1;
  localparam int unsigned M_DMA_OUT   = 2;
  localparam int unsigned NUM_MASTERS = 3;

  // Next master index after idx, wrapping m2 -> m0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx == 2'(NUM_MASTERS - 1)) ? 2'(M_CPU) : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter. The winner is the first requester at or after the
// pointer; the pointer moves past the winner only when the owner strobes advance.
module rr_arb3
  import user_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_req,
  input  logic       i_advance,
  output logic [2:0] o_winner
);

  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  // Priority search starting at the pointer, wrapping around.
  always_comb begin
    w_idx = r_ptr;
    case (r_ptr)
      2'(M_CPU):    w_idx = i_req[0] ? 2'd0 : (i_req[1] ? 2'd1 : 2'd2);
      2'(M_DMA_IN): w_idx = i_req[1] ? 2'd1 : (i_req[2] ? 2'd2 : 2'd0);
      default:      w_idx = i_req[2] ? 2'd2 : (i_req[0] ? 2'd0 : 2'd1);
    endcase
    o_winner = (|i_req) ? (3'b001 << w_idx) : 3'b000;
  end

  // Pointer moves to winner+1 so the last owner has lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'(M_CPU);
    end else if (i_advance && (|i_req)) begin
      r_ptr <= rr_next(w_idx);
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Shares the user-RAM Wishbone slave between the CPU and the two FIR DMA engines.
// One transfer at a time; a watchdog aborts a transfer the RAM never acknowledges.
module wb_ram_arbiter
  import user_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  input  logic        m2_stb_i,
  input  logic        m2_cyc_i,
  input  logic        m2_we_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_adr_i,
  input  logic [31:0] m2_dat_i,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic [31:0] m2_dat_o,
  output logic        ram_stb_o,
  output logic        ram_cyc_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_dat_i,
  output logic [2:0]  grant_o
);

  state_e           r_state;
  logic [2:0]       r_grant;
  logic [CNT_W-1:0] r_wd;

  logic [2:0] w_cyc;
  logic [2:0] w_stb;
  logic [2:0] w_we;
  logic [2:0] w_req;
  logic [2:0] w_winner;
  logic       w_advance;
  logic       w_busy;
  logic       w_gnt_cyc;
  logic       w_timeout;

  assign w_cyc     = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign w_stb     = {m2_stb_i, m1_stb_i, m0_stb_i};
  assign w_we      = {m2_we_i, m1_we_i, m0_we_i};
  assign w_req     = w_cyc & w_stb;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_advance = (r_state == ST_IDLE) && (|w_req);

  // Owner still holds its cycle; once it drops, the transfer is abandoned silently.
  assign w_gnt_cyc = |(r_grant & w_cyc);
  // Ack takes precedence over a timeout in the same cycle.
  assign w_timeout = w_busy && w_gnt_cyc && !ram_ack_i &&
                     (r_wd == CNT_W'(TIMEOUT_CYC - 1));

  rr_arb3 u_rr_arb3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_advance (w_advance),
    .o_winner  (w_winner)
  );

  // r_grant is zero outside BUSY, so the AND-OR muxes idle the RAM port by themselves.
  assign ram_cyc_o = |(r_grant & w_cyc);
  assign ram_stb_o = |(r_grant & w_cyc & w_stb);
  assign ram_we_o  = |(r_grant & w_we);
  assign ram_sel_o = ({4{r_grant[0]}} & m0_sel_i) | ({4{r_grant[1]}} & m1_sel_i) |
                     ({4{r_grant[2]}} & m2_sel_i);
  assign ram_adr_o = ({32{r_grant[0]}} & m0_adr_i) | ({32{r_grant[1]}} & m1_adr_i) |
                     ({32{r_grant[2]}} & m2_adr_i);
  assign ram_dat_o = ({32{r_grant[0]}} & m0_dat_i) | ({32{r_grant[1]}} & m1_dat_i) |
                     ({32{r_grant[2]}} & m2_dat_i);

  assign m0_ack_o = ram_ack_i & w_gnt_cyc & r_grant[0];
  assign m1_ack_o = ram_ack_i & w_gnt_cyc & r_grant[1];
  assign m2_ack_o = ram_ack_i & w_gnt_cyc & r_grant[2];
  assign m0_err_o = w_timeout & r_grant[0];
  assign m1_err_o = w_timeout & r_grant[1];
  assign m2_err_o = w_timeout & r_grant[2];
  assign m0_dat_o = ram_dat_i & {32{r_grant[0]}};
  assign m1_dat_o = ram_dat_i & {32{r_grant[1]}};
  assign m2_dat_o = ram_dat_i & {32{r_grant[2]}};
  assign grant_o  = r_grant;

  // Transfer FSM: IDLE grants, BUSY runs the watchdog, RELEASE forces one dead cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_wd    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant <= w_winner;
            r_wd    <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_wd <= r_wd + CNT_W'(1);
          if (!w_gnt_cyc || ram_ack_i || w_timeout) begin
            r_grant <= 3'b000;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= 3'b000;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed testbench for wb_ram_arbiter with a simple fixed-latency RAM model.
module tb_wb_ram_arbiter;

  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned CNT_W       = 7;

  logic        clk;
  logic        rst_n;
  logic [2:0]  m_cyc;
  logic [2:0]  m_stb;
  logic [2:0]  m_we;
  logic [3:0]  m_sel [3];
  logic [31:0] m_adr [3];
  logic [31:0] m_dat [3];
  logic        m0_ack_o, m1_ack_o, m2_ack_o;
  logic        m0_err_o, m1_err_o, m2_err_o;
  logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o;
  logic        ram_stb_o, ram_cyc_o, ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_adr_o, ram_dat_o;
  logic        ram_ack_i;
  logic [31:0] ram_dat_i;
  logic [2:0]  grant_o;
  logic [2:0]  acks, errs;

  int   total = 0;
  int   bad = 0;
  int   ram_cnt = 0;
  int   ram_lat = 0;
  logic ram_en = 1'b1;
  logic ram_ack_force = 1'b0;

  wb_ram_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .m2_stb_i(m_stb[2]), .m2_cyc_i(m_cyc[2]), .m2_we_i(m_we[2]), .m2_sel_i(m_sel[2]),
    .m2_adr_i(m_adr[2]), .m2_dat_i(m_dat[2]), .m2_ack_o(m2_ack_o), .m2_err_o(m2_err_o),
    .m2_dat_o(m2_dat_o),
    .ram_stb_o(ram_stb_o), .ram_cyc_o(ram_cyc_o), .ram_we_o(ram_we_o),
    .ram_sel_o(ram_sel_o), .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o),
    .ram_ack_i(ram_ack_i), .ram_dat_i(ram_dat_i), .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign acks = {m2_ack_o, m1_ack_o, m0_ack_o};
  assign errs = {m2_err_o, m1_err_o, m0_err_o};

  // RAM model: acks once stb has been held for ram_lat cycles; data derived from address.
  always @(posedge clk) begin
    if (!ram_stb_o || ram_ack_i) ram_cnt <= 0;
    else ram_cnt <= ram_cnt + 1;
  end
  assign ram_ack_i = ram_ack_force | (ram_en & ram_stb_o & (ram_cnt == ram_lat));
  assign ram_dat_i = ram_adr_o ^ 32'hA5A5_0000;

  initial begin
    #1000000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic set_req(input int n, input logic on, input logic [31:0] adr);
    m_cyc[n] = on;
    m_stb[n] = on;
    m_we[n]  = 1'b0;
    m_sel[n] = 4'hF;
    m_adr[n] = adr;
    m_dat[n] = ~adr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle t0 with the DUT idle and pointer at m0.
  task automatic do_reset();
    for (int n = 0; n < 3; n++) set_req(n, 1'b0, 32'h0);
    ram_en = 1'b1;
    ram_lat = 0;
    ram_ack_force = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) set_req(n, 1'b1, 32'h0000_0010 * n);
    #12;
    total++;
    if (grant_o !== 3'b000) begin
      bad++; $display("FAIL rst_grant got=%b want=000", grant_o);
    end
    total++;
    if ({ram_cyc_o, ram_stb_o} !== 2'b00) begin
      bad++; $display("FAIL rst_ram_cyc_stb got=%b want=00", {ram_cyc_o, ram_stb_o});
    end
    total++;
    if ({acks, errs} !== 6'b0) begin
      bad++; $display("FAIL rst_ack_err got=%b want=000000", {acks, errs});
    end
    total++;
    if (m0_dat_o !== 32'h0) begin
      bad++; $display("FAIL rst_m0_dat got=%h want=00000000", m0_dat_o);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    ram_lat = 2;
    set_req(0, 1'b1, 32'h0000_0100);
    @(negedge clk);
    total++;
    if (grant_o !== 3'b000) begin
      bad++; $display("FAIL sr_t0_grant got=%b want=000", grant_o);
    end
    step(); @(negedge clk);
    total++;
    if ({grant_o, ram_cyc_o, ram_stb_o} !== 5'b001_11) begin
      bad++; $display("FAIL sr_t1_grant_stb got=%b want=00111", {grant_o, ram_cyc_o, ram_stb_o});
    end
    total++;
    if ({ram_adr_o, ram_dat_o} !== {32'h0000_0100, 32'hFFFF_FEFF}) begin
      bad++; $display("FAIL sr_t1_adr_dat got=%h %h want=00000100 fffffeff", ram_adr_o, ram_dat_o);
    end
    step(); @(negedge clk);
    total++;
    if (acks !== 3'b000) begin
      bad++; $display("FAIL sr_t2_ack got=%b want=000", acks);
    end
    step(); @(negedge clk);
    total++;
    if ({grant_o, acks} !== 6'b001_001) begin
      bad++; $display("FAIL sr_t3_grant_ack got=%b want=001001", {grant_o, acks});
    end
    total++;
    if ({m0_dat_o, m1_dat_o} !== {32'hA5A5_0100, 32'h0}) begin
      bad++; $display("FAIL sr_t3_rdata got=%h %h want=a5a50100 00000000", m0_dat_o, m1_dat_o);
    end
    step();
    set_req(0, 1'b0, 32'h0);
    @(negedge clk);
    total++;
    if ({grant_o, ram_cyc_o, ram_stb_o} !== 5'b000_00) begin
      bad++; $display("FAIL sr_t4_release got=%b want=00000", {grant_o, ram_cyc_o, ram_stb_o});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    ram_lat = 0;
    for (int n = 0; n < 3; n++) set_req(n, 1'b1, 32'h0000_1000 + n);
    for (int c = 1; c <= 12; c++) begin
      step(); @(negedge clk);
      exp_g = 3'b000;
      if (c % 3 == 1) exp_g[((c - 1) / 3) % 3] = 1'b1;
      total++;
      if ({grant_o, acks} !== {exp_g, exp_g}) begin
        bad++; $display("FAIL rr_c%0d grant_ack got=%b want=%b", c, {grant_o, acks}, {exp_g, exp_g});
      end
      total++;
      if ({ram_cyc_o, ram_stb_o} !== {2{|exp_g}}) begin
        bad++; $display("FAIL rr_c%0d ram_cyc_stb got=%b want=%b", c, {ram_cyc_o, ram_stb_o},
                        {2{|exp_g}});
      end
    end
  endtask

  task automatic test_pointer_order();
    logic [2:0] t_add [1:14] = '{3'b000, 3'b000, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] t_drop [1:14] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                                  3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001};
    logic [2:0] exp_g [1:14] = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000,
                                 3'b010, 3'b010, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
    logic [2:0] exp_a [1:14] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000,
                                 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    do_reset();
    ram_lat = 0;
    set_req(1, 1'b1, 32'h0000_2001);
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 3) ram_lat = 1;
      for (int n = 0; n < 3; n++) begin
        if (t_add[c][n]) set_req(n, 1'b1, 32'h0000_2000 + n);
        if (t_drop[c][n]) set_req(n, 1'b0, 32'h0);
      end
      @(negedge clk);
      total++;
      if ({grant_o, acks} !== {exp_g[c], exp_a[c]}) begin
        bad++; $display("FAIL po_c%0d grant_ack got=%b want=%b", c, {grant_o, acks},
                        {exp_g[c], exp_a[c]});
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_g;
    logic [2:0] exp_e;
    do_reset();
    ram_en = 1'b0;
    set_req(1, 1'b1, 32'h0000_0200);
    for (int c = 1; c <= 131; c++) begin
      step();
      if (c == 2) set_req(2, 1'b1, 32'h0000_0300);
      if (c == 65) set_req(1, 1'b0, 32'h0);
      @(negedge clk);
      exp_g = (c <= 64) ? 3'b010 : ((c >= 67 && c <= 130) ? 3'b100 : 3'b000);
      exp_e = (c == 64) ? 3'b010 : ((c == 130) ? 3'b100 : 3'b000);
      total++;
      if ({grant_o, errs, acks} !== {exp_g, exp_e, 3'b000}) begin
        bad++; $display("FAIL to_c%0d grant_err_ack got=%b want=%b", c, {grant_o, errs, acks},
                        {exp_g, exp_e, 3'b000});
      end
      if (c == 64) begin
        total++;
        if ({ram_cyc_o, ram_stb_o} !== 2'b11) begin
          bad++; $display("FAIL to_err_cycle_stb got=%b want=11", {ram_cyc_o, ram_stb_o});
        end
      end
    end
  endtask

  task automatic test_drop_cyc();
    do_reset();
    ram_lat = 5;
    set_req(2, 1'b1, 32'h0000_0400);
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge clk);
      total++;
      if ({grant_o, ram_cyc_o, ram_stb_o} !== 5'b100_11) begin
        bad++; $display("FAIL dc_c%0d busy got=%b want=10011", c, {grant_o, ram_cyc_o, ram_stb_o});
      end
    end
    step();
    m_cyc[2] = 1'b0;
    @(negedge clk);
    total++;
    if ({grant_o, ram_cyc_o, ram_stb_o, acks, errs} !== 11'b100_00_000_000) begin
      bad++; $display("FAIL dc_drop got=%b want=10000000000",
                      {grant_o, ram_cyc_o, ram_stb_o, acks, errs});
    end
    for (int c = 5; c <= 6; c++) begin
      step();
      ram_ack_force = 1'b1;
      @(negedge clk);
      total++;
      if ({grant_o, acks, errs} !== 9'b0) begin
        bad++; $display("FAIL dc_c%0d late_ack got=%b want=000000000", c, {grant_o, acks, errs});
      end
      total++;
      if (m2_dat_o !== 32'h0) begin
        bad++; $display("FAIL dc_c%0d m2_dat got=%h want=00000000", c, m2_dat_o);
      end
    end
    ram_ack_force = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ram_en = 1'b0;
    set_req(1, 1'b1, 32'h0000_0500);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) set_req(0, 1'b1, 32'h0000_0600);
    end
    @(negedge clk);
    total++;
    if ({grant_o, ram_cyc_o, ram_stb_o} !== 5'b010_11) begin
      bad++; $display("FAIL ar_busy got=%b want=01011", {grant_o, ram_cyc_o, ram_stb_o});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ram_ack_force = 1'b1;
    #1;
    total++;
    if ({grant_o, ram_cyc_o, ram_stb_o, acks, errs} !== 11'b0) begin
      bad++; $display("FAIL ar_immediate got=%b want=00000000000",
                      {grant_o, ram_cyc_o, ram_stb_o, acks, errs});
    end
    total++;
    if (m1_dat_o !== 32'h0) begin
      bad++; $display("FAIL ar_m1_dat got=%h want=00000000", m1_dat_o);
    end
    step(); step(); @(negedge clk);
    total++;
    if ({grant_o, ram_stb_o, acks} !== 7'b0) begin
      bad++; $display("FAIL ar_held got=%b want=0000000", {grant_o, ram_stb_o, acks});
    end
    ram_ack_force = 1'b0;
    step();
    rst_n = 1'b1;
    step(); @(negedge clk);
    total++;
    if ({grant_o, ram_adr_o} !== {3'b001, 32'h0000_0600}) begin
      bad++; $display("FAIL ar_first_grant got=%b %h want=001 00000600", grant_o, ram_adr_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) set_req(n, 1'b0, 32'h0);
    test_reset();
    test_single_read();
    test_round_robin();
    test_pointer_order();
    test_timeout();
    test_drop_cyc();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
